// File: rtl/ps2_keymatrix_pkg.sv
// Shared constants, decode state type and the PS/2 set-2 to key matrix map.
package ps2_keymatrix_pkg;

   localparam logic [7:0] CODE_E0   = 8'hE0;
   localparam logic [7:0] CODE_F0   = 8'hF0;
   localparam logic [7:0] CODE_E1   = 8'hE1;
   localparam logic [7:0] CAPS_CODE = 8'h58;

   // Matrix index = column*8 + row
   localparam logic [5:0] KEY_EQUAL = 6'd0;
   localparam logic [5:0] KEY_SPACE = 6'd1;
   localparam logic [5:0] KEY_ENTER = 6'd2;
   localparam logic [5:0] KEY_SHIFT = 6'd3;
   localparam logic [5:0] KEY_FCTN  = 6'd4;
   localparam logic [5:0] KEY_CTRL  = 6'd6;
   localparam logic [5:0] KEY_A     = 6'd21;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXTBRK
   } dec_state_e;

   typedef struct packed {
      logic       hit;
      logic [5:0] index;
   } key_map_t;

   // Left Ctrl (0x14) is deliberately unmapped so the Pause sequence
   // (E1 14 77 ...) never disturbs the matrix; only right Ctrl drives CTRL.
   function automatic key_map_t ps2_to_ti(input logic ext, input logic [7:0] code);
      key_map_t m;
      m.hit   = 1'b1;
      m.index = '0;
      case ({ext, code})
         9'h01C:  m.index = KEY_A;
         9'h012:  m.index = KEY_SHIFT;
         9'h059:  m.index = KEY_SHIFT;
         9'h05A:  m.index = KEY_ENTER;
         9'h15A:  m.index = KEY_ENTER;
         9'h011:  m.index = KEY_FCTN;
         9'h111:  m.index = KEY_FCTN;
         9'h114:  m.index = KEY_CTRL;
         9'h029:  m.index = KEY_SPACE;
         9'h055:  m.index = KEY_EQUAL;
         default: m.hit   = 1'b0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/ps2_keymatrix_rx.sv
// PS/2 device-to-host frame receiver: synchroniser, clock glitch filter,
// bit counter, parity/stop check and mid-frame timeout.
module ps2_rx #(
   parameter int unsigned timeout_cycles = 1100,
   parameter int unsigned filter_len     = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       scan_valid,
   output logic [7:0] scan_code,
   output logic       frame_err
);

   localparam int unsigned TO_W = $clog2(timeout_cycles + 1);
   localparam int unsigned FL_W = $clog2(filter_len + 1);
   localparam logic [TO_W-1:0] TO_LOAD = TO_W'(timeout_cycles);
   localparam logic [FL_W-1:0] FL_LAST = FL_W'(filter_len - 1);

   logic [1:0]      clk_sync_q, clk_sync_d;
   logic [1:0]      dat_sync_q, dat_sync_d;
   logic            filt_q, filt_d;
   logic [FL_W-1:0] flt_cnt_q, flt_cnt_d;
   logic [3:0]      bit_cnt_q, bit_cnt_d;
   logic [7:0]      shift_q, shift_d;
   logic            par_q, par_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            scan_valid_q, scan_valid_d;
   logic [7:0]      scan_code_q, scan_code_d;
   logic            frame_err_q, frame_err_d;
   logic            fall;
   logic            sdat;

   // Filter, frame assembly and timeout next-state
   always_comb begin
      clk_sync_d   = {clk_sync_q[0], ps2_clk};
      dat_sync_d   = {dat_sync_q[0], ps2_data};
      filt_d       = filt_q;
      flt_cnt_d    = '0;
      fall         = 1'b0;
      sdat         = dat_sync_q[1];
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      par_d        = par_q;
      to_cnt_d     = to_cnt_q;
      scan_valid_d = 1'b0;
      scan_code_d  = scan_code_q;
      frame_err_d  = 1'b0;

      // A level change is accepted only after filter_len differing samples
      if (clk_sync_q[1] != filt_q) begin
         if (flt_cnt_q == FL_LAST) begin
            filt_d = clk_sync_q[1];
            fall   = filt_q;
         end else begin
            flt_cnt_d = flt_cnt_q + 1'b1;
         end
      end

      if (fall) begin
         to_cnt_d = TO_LOAD;
         case (bit_cnt_q)
            4'd0: begin
               if (sdat) frame_err_d = 1'b1;
               else      bit_cnt_d   = 4'd1;
            end
            4'd9: begin
               par_d     = sdat;
               bit_cnt_d = 4'd10;
            end
            4'd10: begin
               bit_cnt_d = 4'd0;
               if (sdat && (^{shift_q, par_q})) begin
                  scan_valid_d = 1'b1;
                  scan_code_d  = shift_q;
               end else begin
                  frame_err_d = 1'b1;
               end
            end
            default: begin
               shift_d   = {sdat, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 4'd1;
            end
         endcase
      end else if (bit_cnt_q != 4'd0) begin
         // Down-counter parks at zero until the next edge reloads it
         if (to_cnt_q == '0) begin
            frame_err_d = 1'b1;
            bit_cnt_d   = 4'd0;
         end else begin
            to_cnt_d = to_cnt_q - 1'b1;
         end
      end
   end

   // Receiver registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         clk_sync_q   <= 2'b11;
         dat_sync_q   <= 2'b11;
         filt_q       <= 1'b1;
         flt_cnt_q    <= '0;
         bit_cnt_q    <= 4'd0;
         shift_q      <= 8'h00;
         par_q        <= 1'b0;
         to_cnt_q     <= '0;
         scan_valid_q <= 1'b0;
         scan_code_q  <= 8'h00;
         frame_err_q  <= 1'b0;
      end else begin
         clk_sync_q   <= clk_sync_d;
         dat_sync_q   <= dat_sync_d;
         filt_q       <= filt_d;
         flt_cnt_q    <= flt_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         par_q        <= par_d;
         to_cnt_q     <= to_cnt_d;
         scan_valid_q <= scan_valid_d;
         scan_code_q  <= scan_code_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign scan_valid = scan_valid_q;
   assign scan_code  = scan_code_q;
   assign frame_err  = frame_err_q;

endmodule

// File: rtl/ps2_keymatrix.sv
// PS/2 keyboard to console key matrix bridge.
//
// state     | meaning
// ----------+-----------------------------------------
// ST_IDLE   | no prefix pending
// ST_EXT    | E0 seen, next code is an extended make
// ST_BRK    | F0 seen, next code is a release
// ST_EXTBRK | E0 F0 seen, next code is an extended release
module ps2_keymatrix
   import ps2_keymatrix_pkg::*;
#(
   parameter int unsigned clk_multiplier = 1,
   parameter int unsigned timeout_cycles = 1100 * clk_multiplier,
   parameter int unsigned filter_len     = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [0:47] key_state,
   output logic        alpha_state,
   output logic        scan_valid,
   output logic [0:7]  scan_code,
   output logic        frame_err
);

   logic       rx_valid;
   logic [7:0] rx_code;
   logic       rx_err;

   ps2_rx #(
      .timeout_cycles (timeout_cycles),
      .filter_len     (filter_len)
   ) u_rx (
      .clk        (clk),
      .reset_n    (reset_n),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .scan_valid (rx_valid),
      .scan_code  (rx_code),
      .frame_err  (rx_err)
   );

   dec_state_e  state_q, state_d;
   logic        ev_make, ev_break, ev_ext;
   key_map_t    km;
   logic [0:47] key_state_q, key_state_d;
   logic        alpha_q, alpha_d;
   logic        caps_held_q, caps_held_d;

   // Decode state register
   always_ff @(posedge clk) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Prefix tracking
   always_comb begin
      state_d = state_q;
      if (rx_err) begin
         state_d = ST_IDLE;
      end else if (rx_valid) begin
         case (state_q)
            ST_IDLE: begin
               if      (rx_code == CODE_E0) state_d = ST_EXT;
               else if (rx_code == CODE_F0) state_d = ST_BRK;
               else                         state_d = ST_IDLE;
            end
            ST_EXT: begin
               if      (rx_code == CODE_F0) state_d = ST_EXTBRK;
               else if (rx_code == CODE_E0) state_d = ST_EXT;
               else                         state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Make/break events for the current byte
   always_comb begin
      ev_make  = 1'b0;
      ev_break = 1'b0;
      ev_ext   = 1'b0;
      if (rx_valid) begin
         case (state_q)
            ST_IDLE: ev_make = (rx_code != CODE_E0) && (rx_code != CODE_F0) &&
                               (rx_code != CODE_E1);
            ST_EXT: begin
               ev_make = (rx_code != CODE_E0) && (rx_code != CODE_F0);
               ev_ext  = 1'b1;
            end
            ST_BRK: ev_break = 1'b1;
            ST_EXTBRK: begin
               ev_break = 1'b1;
               ev_ext   = 1'b1;
            end
            default: ev_make = 1'b0;
         endcase
      end
   end

   // Key matrix and Alpha Lock next-state
   always_comb begin
      km          = ps2_to_ti(ev_ext, rx_code);
      key_state_d = key_state_q;
      alpha_d     = alpha_q;
      caps_held_d = caps_held_q;
      if (ev_make && km.hit)  key_state_d[km.index] = 1'b1;
      if (ev_break && km.hit) key_state_d[km.index] = 1'b0;
      // Typematic repeats of Caps Lock must not keep toggling
      if (!ev_ext && (rx_code == CAPS_CODE)) begin
         if (ev_make && !caps_held_q) begin
            alpha_d     = ~alpha_q;
            caps_held_d = 1'b1;
         end
         if (ev_break) caps_held_d = 1'b0;
      end
   end

   // Key matrix registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         key_state_q <= '0;
         alpha_q     <= 1'b0;
         caps_held_q <= 1'b0;
      end else begin
         key_state_q <= key_state_d;
         alpha_q     <= alpha_d;
         caps_held_q <= caps_held_d;
      end
   end

   assign key_state   = key_state_q;
   assign alpha_state = alpha_q;
   assign scan_valid  = rx_valid;
   assign scan_code   = rx_code;
   assign frame_err   = rx_err;

endmodule

// File: tb/tb_ps2_keymatrix.sv
// Bench for ps2_keymatrix: drives PS/2 frames, scoreboards accepted bytes.
module tb_ps2_keymatrix;

   localparam int HALF = 20;

   logic        clk      = 1'b0;
   logic        reset_n  = 1'b0;
   logic        ps2_clk  = 1'b1;
   logic        ps2_data = 1'b1;
   logic [0:47] key_state;
   logic        alpha_state;
   logic        scan_valid;
   logic [0:7]  scan_code;
   logic        frame_err;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] exp_q[$];
   int sv_pulses = 0, sv_cycles = 0, fe_pulses = 0, fe_cycles = 0;
   int exp_sv = 0, exp_fe = 0;
   logic sv_prev = 1'b0, fe_prev = 1'b0;
   logic [0:47] exp_keys;
   logic [7:0]  exp_code;

   ps2_keymatrix dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .key_state   (key_state),
      .alpha_state (alpha_state),
      .scan_valid  (scan_valid),
      .scan_code   (scan_code),
      .frame_err   (frame_err)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   // Scoreboard and pulse-width monitor
   always @(negedge clk) begin
      if (scan_valid) begin
         sv_cycles++;
         if (!sv_prev) begin
            sv_pulses++;
            if (exp_q.size() == 0) begin
               check_val("sb_unexpected", {40'h0, scan_code}, 48'h1ff);
            end else begin
               exp_code = exp_q.pop_front();
               check_val("scan_code", {40'h0, scan_code}, {40'h0, exp_code});
            end
         end
      end
      if (frame_err) begin
         fe_cycles++;
         if (!fe_prev) fe_pulses++;
      end
      sv_prev = scan_valid;
      fe_prev = frame_err;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic send_bit(input logic d);
      ps2_data = d;
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit((~^b) ^ bad_par);
      send_bit(~bad_stop);
      ps2_data = 1'b1;
      repeat (HALF) @(posedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      exp_q.push_back(b);
      exp_sv++;
      send_frame(b, 1'b0, 1'b0);
   endtask

   task automatic send_bad(input logic [7:0] b, input logic bp, input logic bs);
      exp_fe++;
      send_frame(b, bp, bs);
   endtask

   task automatic check_keys(input string tag, input logic [0:47] exp, input logic exp_alpha);
      repeat (5) @(posedge clk);
      @(negedge clk);
      check_val(tag, key_state, exp);
      check_val({tag, "_alpha"}, {47'h0, alpha_state}, {47'h0, exp_alpha});
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_keys"}, key_state, 48'h0);
      check_val({tag, "_alpha"}, {47'h0, alpha_state}, 48'h0);
      check_val({tag, "_valid"}, {47'h0, scan_valid}, 48'h0);
      check_val({tag, "_code"}, {40'h0, scan_code}, 48'h0);
      check_val({tag, "_err"}, {47'h0, frame_err}, 48'h0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      reset_n = 1'b1;
      repeat (10) @(posedge clk);

      // Clock glitch shorter than the filter must be ignored
      ps2_clk = 1'b0;
      repeat (2) @(posedge clk);
      ps2_clk = 1'b1;
      repeat (20) @(posedge clk);
      check_val("glitch_err", fe_pulses, exp_fe);

      // A press and release
      exp_keys = '0;
      send_byte(8'h1C);
      exp_keys[21] = 1'b1;
      check_keys("a_make", exp_keys, 1'b0);
      send_byte(8'hF0);
      send_byte(8'h1C);
      exp_keys[21] = 1'b0;
      check_keys("a_break", exp_keys, 1'b0);

      // Keypad Enter make/break, then plain make proves FSM is idle
      send_byte(8'hE0);
      send_byte(8'h5A);
      exp_keys[2] = 1'b1;
      check_keys("kpent_make", exp_keys, 1'b0);
      send_byte(8'hE0);
      send_byte(8'hF0);
      send_byte(8'h5A);
      exp_keys[2] = 1'b0;
      check_keys("kpent_break", exp_keys, 1'b0);
      send_byte(8'h1C);
      exp_keys[21] = 1'b1;
      check_keys("idle_after_ext", exp_keys, 1'b0);
      send_byte(8'hF0);
      send_byte(8'h1C);
      exp_keys[21] = 1'b0;

      // Parity and stop errors drop the byte
      send_bad(8'h1C, 1'b1, 1'b0);
      check_keys("bad_parity", exp_keys, 1'b0);
      check_val("bad_parity_err", fe_pulses, exp_fe);
      send_bad(8'h1C, 1'b0, 1'b1);
      check_val("bad_stop_err", fe_pulses, exp_fe);
      send_byte(8'h12);
      exp_keys[3] = 1'b1;
      check_keys("shift_make", exp_keys, 1'b0);

      // Timeout mid-frame
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      exp_fe++;
      repeat (1300) @(posedge clk);
      check_val("timeout_err", fe_pulses, exp_fe);

      // Caps Lock toggling with typematic repeat
      send_byte(8'h58);
      check_keys("caps_on", exp_keys, 1'b1);
      send_byte(8'h58);
      send_byte(8'h58);
      check_keys("caps_repeat", exp_keys, 1'b1);
      send_byte(8'hF0);
      send_byte(8'h58);
      check_keys("caps_release", exp_keys, 1'b1);
      send_byte(8'h58);
      check_keys("caps_off", exp_keys, 1'b0);

      // Pause sequence has no key effect
      send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77);
      send_byte(8'hE1); send_byte(8'hF0); send_byte(8'h14);
      send_byte(8'hF0); send_byte(8'h77);
      check_keys("pause", exp_keys, 1'b0);

      // Shared index: last event wins
      send_byte(8'hF0);
      send_byte(8'h59);
      exp_keys[3] = 1'b0;
      check_keys("shared_idx", exp_keys, 1'b0);

      // Reset mid-frame with two keys held
      send_byte(8'h12);
      send_byte(8'h1C);
      exp_keys[3]  = 1'b1;
      exp_keys[21] = 1'b1;
      check_keys("two_held", exp_keys, 1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      check_all_zero("midreset");
      @(negedge clk);
      reset_n = 1'b1;
      ps2_data = 1'b1;
      repeat (10) @(posedge clk);
      exp_keys = '0;
      send_byte(8'h5A);
      exp_keys[2] = 1'b1;
      check_keys("after_reset", exp_keys, 1'b0);
      send_byte(8'h5A);
      check_keys("typematic", exp_keys, 1'b0);

      repeat (20) @(posedge clk);
      @(negedge clk);
      check_val("valid_pulses", sv_pulses, exp_sv);
      check_val("valid_width", sv_cycles, exp_sv);
      check_val("err_pulses", fe_pulses, exp_fe);
      check_val("err_width", fe_cycles, exp_fe);
      check_val("sb_left", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
